// File: rtl/data_mem_sb.sv
// Data memory with a store buffer in front of a single-write-port word array.
// Stores are queued in a FIFO and drained into the array on cycles without a
// load; loads see the youngest buffered value for their word, or the array.
module data_mem_sb #(
    parameter int AW  = 6,
    parameter int SBD = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        memwrite_m_i,
    input  logic        memread_m_i,
    input  logic [31:0] aluout_m_i,
    input  logic [31:0] writedata_m_i,
    output logic [31:0] readdata_m_o,
    output logic        stall_m_o,
    output logic [3:0]  sb_count_o,
    output logic        sb_empty_o
);

    localparam int PW    = $clog2(SBD);
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem     [DEPTH];
    logic [AW-1:0] sb_idx  [SBD];
    logic [31:0]   sb_data [SBD];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [3:0]    count;

    logic [AW-1:0] word;
    logic          full;
    logic          deq;
    logic          enq;
    logic          unused_addr_bits;

    // Byte offset and bits above the array size do not select a word.
    assign word             = aluout_m_i[AW+1:2];
    assign unused_addr_bits = ^{aluout_m_i[31:AW+2], aluout_m_i[1:0]};

    // The array port belongs to the load whenever one is present, so the
    // drain only runs on load-free cycles. A full buffer that drains this
    // cycle frees a slot in time for the incoming store.
    assign full      = (count == 4'(SBD));
    assign deq       = (count != 4'd0) && !memread_m_i;
    assign enq       = memwrite_m_i && (!full || deq);
    assign stall_m_o = memwrite_m_i && full && !deq;

    assign sb_count_o = count;
    assign sb_empty_o = (count == 4'd0);

    // FIFO pointers and occupancy; pointers wrap naturally at SBD.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (deq)
                head <= head + 1'b1;
            if (enq && !deq)
                count <= count + 4'd1;
            else if (deq && !enq)
                count <= count - 4'd1;
        end
    end

    // Buffer payload; only entries inside [head, head+count) are ever used.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            sb_idx[tail]  <= word;
            sb_data[tail] <= writedata_m_i;
        end
    end

    // Word array, cleared on reset and written only by the drain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (deq) begin
            mem[sb_idx[head]] <= sb_data[head];
        end
    end

    // Load path: walk entries oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] pos;
        pos          = '0;
        readdata_m_o = mem[word];
        for (int i = 0; i < SBD; i++) begin
            pos = head + PW'(i);
            if ((4'(i) < count) && (sb_idx[pos] == word))
                readdata_m_o = sb_data[pos];
        end
    end

endmodule

// File: tb/tb_data_mem_sb.sv
// Directed and randomized checks for data_mem_sb (AW=6, SBD=4).
module tb_data_mem_sb;

    logic        clk;
    logic        reset_i;
    logic        memwrite_m_i;
    logic        memread_m_i;
    logic [31:0] aluout_m_i;
    logic [31:0] writedata_m_i;
    logic [31:0] readdata_m_o;
    logic        stall_m_o;
    logic [3:0]  sb_count_o;
    logic        sb_empty_o;

    int tests;
    int fails;

    data_mem_sb #(.AW(6), .SBD(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .memwrite_m_i (memwrite_m_i),
        .memread_m_i  (memread_m_i),
        .aluout_m_i   (aluout_m_i),
        .writedata_m_i(writedata_m_i),
        .readdata_m_o (readdata_m_o),
        .stall_m_o    (stall_m_o),
        .sb_count_o   (sb_count_o),
        .sb_empty_o   (sb_empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, then let combinational outputs settle before checking.
    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        memwrite_m_i  = w;
        memread_m_i   = r;
        aluout_m_i    = a;
        writedata_m_i = d;
        #1;
    endtask

    logic [31:0] gmem [64];
    int          gcount;
    logic        rw, rr, mdeq, mstall, hold;
    logic [31:0] ra, rd;
    logic [2:0]  ridx;
    logic [5:0]  gi;

    initial begin
        tests = 0;
        fails = 0;
        reset_i = 1'b1;
        memwrite_m_i = 1'b0;
        memread_m_i = 1'b0;
        aluout_m_i = '0;
        writedata_m_i = '0;
        #2;
        chk("rst_stall", 32'(stall_m_o), 32'd0);
        chk("rst_count", 32'(sb_count_o), 32'd0);
        chk("rst_empty", 32'(sb_empty_o), 32'd1);
        chk("rst_rdata", readdata_m_o, 32'd0);

        // Store presented while reset is still high; it must enqueue on the
        // first edge after release (t=15).
        drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        #8;
        reset_i = 1'b0;
        #1;
        chk("pre_edge_count", 32'(sb_count_o), 32'd0);
        tick();
        chk("first_enq_count", 32'(sb_count_o), 32'd1);
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        chk("bypass_idle", readdata_m_o, 32'hDEADBEEF);
        chk("array_before_drain", dut.mem[4], 32'h0);
        tick();
        chk("drain_count", 32'(sb_count_o), 32'd0);
        chk("array_after_drain", dut.mem[4], 32'hDEADBEEF);
        tick();
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        chk("load_0x10", readdata_m_o, 32'hDEADBEEF);
        chk("load_0x10_empty", 32'(sb_empty_o), 32'd1);

        // Two stores to one word; the second arrives with a load pending,
        // which must not see the store of its own cycle.
        drive(1'b1, 1'b0, 32'h20, 32'h11111111);
        tick();
        drive(1'b1, 1'b1, 32'h20, 32'h22222222);
        chk("no_same_cycle_fwd", readdata_m_o, 32'h11111111);
        tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        chk("bypass_youngest", readdata_m_o, 32'h22222222);
        chk("bypass_count", 32'(sb_count_o), 32'd2);
        chk("bypass_array_zero", dut.mem[8], 32'h0);
        tick();
        chk("suspended_count", 32'(sb_count_o), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        chk("drained_0x20", readdata_m_o, 32'h22222222);
        chk("array_0x20", dut.mem[8], 32'h22222222);

        // Fill the buffer while loads block the drain.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h40 + 32'(i * 4), 32'(i + 1));
            tick();
        end
        drive(1'b1, 1'b1, 32'h50, 32'h5);
        chk("full_count", 32'(sb_count_o), 32'd4);
        chk("full_stall", 32'(stall_m_o), 32'd1);
        tick();
        chk("stalled_count", 32'(sb_count_o), 32'd4);
        drive(1'b0, 1'b1, 32'h50, 32'h0);
        chk("stalled_not_stored", readdata_m_o, 32'h0);
        drive(1'b1, 1'b0, 32'h50, 32'h5);
        chk("stall_clears", 32'(stall_m_o), 32'd0);
        tick();
        chk("full_enq_deq_count", 32'(sb_count_o), 32'd4);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            tick();
        chk("full_drained", 32'(sb_count_o), 32'd0);
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        chk("load_0x40", readdata_m_o, 32'h1);
        drive(1'b0, 1'b1, 32'h4C, 32'h0);
        chk("load_0x4c", readdata_m_o, 32'h4);
        drive(1'b0, 1'b1, 32'h50, 32'h0);
        chk("load_0x50", readdata_m_o, 32'h5);

        // Aliased addresses 0x04 and 0x104 share word 1.
        drive(1'b1, 1'b0, 32'h04, 32'hAAAA0001);
        tick();
        drive(1'b1, 1'b0, 32'h104, 32'hBBBB0002);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("alias_drained", 32'(sb_count_o), 32'd0);
        drive(1'b0, 1'b1, 32'h04, 32'h0);
        chk("alias_load", readdata_m_o, 32'hBBBB0002);
        chk("alias_array", dut.mem[1], 32'hBBBB0002);

        // Asynchronous reset with three stores pending.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h60 + 32'(i * 4), 32'(i + 7));
            tick();
        end
        drive(1'b0, 1'b1, 32'h64, 32'h0);
        chk("pending_count", 32'(sb_count_o), 32'd3);
        chk("pending_bypass", readdata_m_o, 32'h8);
        #1;
        reset_i = 1'b1;
        #1;
        chk("async_count", 32'(sb_count_o), 32'd0);
        chk("async_empty", 32'(sb_empty_o), 32'd1);
        chk("async_rdata", readdata_m_o, 32'h0);
        drive(1'b1, 1'b0, 32'h64, 32'h9);
        chk("async_stall", 32'(stall_m_o), 32'd0);
        tick();
        reset_i = 1'b0;
        drive(1'b0, 1'b1, 32'h60, 32'h0);
        chk("discard_0x60", readdata_m_o, 32'h0);
        drive(1'b0, 1'b1, 32'h68, 32'h0);
        chk("discard_0x68", readdata_m_o, 32'h0);
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        chk("array_cleared", readdata_m_o, 32'h0);
        tick();

        // Random mix against a flat word-array model.
        for (int i = 0; i < 64; i++)
            gmem[i] = '0;
        gcount = 0;
        hold = 1'b0;
        rw = 1'b0;
        rr = 1'b0;
        ra = '0;
        rd = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                rw   = ($urandom_range(0, 1) == 1);
                rr   = ($urandom_range(0, 9) < 4);
                ridx = 3'($urandom_range(0, 7));
                ra   = ($urandom() & ~32'hFC) | ({29'b0, ridx} << 2);
                rd   = $urandom();
            end
            drive(rw, rr, ra, rd);
            gi     = ra[7:2];
            mdeq   = (gcount > 0) && !rr;
            mstall = rw && (gcount == 4) && !mdeq;
            chk("rnd_rdata", readdata_m_o, gmem[gi]);
            chk("rnd_stall", 32'(stall_m_o), 32'(mstall));
            chk("rnd_count", 32'(sb_count_o), 32'(gcount));
            if (rw && !mstall) begin
                gmem[gi] = rd;
                gcount++;
            end
            if (mdeq)
                gcount--;
            hold = mstall;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++)
            tick();
        chk("rnd_final_empty", 32'(sb_empty_o), 32'd1);
        for (int i = 0; i < 64; i++)
            chk("rnd_final_array", dut.mem[i], gmem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_sb.md
DATA_MEM_SB -- requirements
Module: data_mem_sb

Interface
REQ-001 Parameter AW, default 6: log2 of data array depth in 32-bit words (64 words).
REQ-002 Parameter SBD, default 4: store-buffer entries; SHALL be a power of two, 2..8.
REQ-003 clk_i  input  1  sole clock; all state updates on posedge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 memwrite_m_i  input  1  store request from memory stage, this cycle.
REQ-006 memread_m_i  input  1  load request from memory stage, this cycle.
REQ-007 aluout_m_i  input  32  byte address; word index = aluout_m_i[AW+1:2], bits [1:0] and above AW+1 ignored.
REQ-008 writedata_m_i  input  32  store data.
REQ-009 readdata_m_o  output  32  load data, combinational, same cycle as request.
REQ-010 stall_m_o  output  1  store not accepted this cycle; requester SHALL hold the request.
REQ-011 sb_count_o  output  4  number of valid store-buffer entries.
REQ-012 sb_empty_o  output  1  high when sb_count_o == 0.

Function
REQ-013 Array SHALL be 2^AW x 32 words, single write port, combinational read.
REQ-014 Store buffer SHALL be a FIFO of SBD entries {word index, data}, with head/tail pointers wrapping modulo SBD and a count 0..SBD.
REQ-015 Enqueue: memwrite_m_i=1 and (count<SBD or dequeue this cycle) -> entry written at tail on posedge; tail+1.
REQ-016 Dequeue (drain): count>0 and memread_m_i=0 -> head entry written into array on posedge; head+1.
REQ-017 Drain SHALL be suspended in any cycle with memread_m_i=1 (array port reserved for the load).
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged; full buffer with dequeue SHALL accept the enqueue (no stall).
REQ-019 stall_m_o = memwrite_m_i & (count==SBD) & ~dequeue, combinational; stalled store SHALL not modify any state.
REQ-020 Load data: readdata_m_o SHALL equal data of the youngest valid buffer entry whose index matches; else array word at index.
REQ-021 Multiple buffer entries to the same index SHALL all be kept and drained in order; array ends with the youngest value.
REQ-022 readdata_m_o SHALL reflect array/buffer state before the current posedge (no same-cycle store forwarding to a load).
REQ-023 memwrite_m_i and memread_m_i both high: load served per REQ-020, store enqueued per REQ-015, drain suspended.
REQ-024 readdata_m_o SHALL be driven with the REQ-020 value whenever memread_m_i=0 as well (value unspecified only by content, not X-gated).
REQ-025 Store-to-array latency with empty buffer and no loads: exactly 2 posedges after request cycle's posedge count 1 (enqueue edge, drain edge).
REQ-026 sb_count_o SHALL never exceed SBD or underflow; pointers SHALL wrap without gap.

Reset
REQ-027 reset_i high SHALL immediately clear head, tail, count, all buffer valid state, and every array word to 0.
REQ-028 During and after reset: stall_m_o=0, sb_count_o=0, sb_empty_o=1, readdata_m_o=0.
REQ-029 Reset asserted mid-drain SHALL discard all pending buffered stores (not written to array).
REQ-030 First enqueue SHALL occur on the first posedge after reset_i deasserts.

Verification
REQ-031 Reset, then store 0xDEADBEEF to 0x10, idle 2 cycles, load 0x10 -> readdata 0xDEADBEEF, sb_empty_o=1.
REQ-032 Store 0x11111111 then 0x22222222 to 0x20, load 0x20 next cycle with drain suspended -> readdata 0x22222222 (bypass), array still 0.
REQ-033 Four stores with memread_m_i held high each cycle, fifth store -> sb_count_o=4, stall_m_o=1; drop memread -> stall clears same cycle, count stays 4.
REQ-034 Store to 0x04 and 0x104 (AW=6, same index) back-to-back, drain fully -> load 0x04 returns second value.
REQ-035 Three stores pending, assert reset_i asynchronously between edges -> outputs reset instantly, loads of those addresses return 0.
REQ-036 Random store/load mix vs. golden word-array model over 10k cycles -> readdata_m_o matches on every load, no count overflow.
